// File: rtl/gtech_jk_excite_ctrl.sv
// Excitation controller for a bank of JK flops. It derives J/K from a target word and the
// current Q, drives them for one cycle, checks the readback and retries on mismatch.
module gtech_jk_excite_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MAX_RETRY  = 3,
  parameter bit          USE_TOGGLE = 1'b0
) (
  input  logic                               CP,
  input  logic                               CD,
  input  logic                               REQ,
  input  logic [WIDTH-1:0]                   TGT,
  input  logic [WIDTH-1:0]                   MASK,
  input  logic [WIDTH-1:0]                   QF,
  output logic [WIDTH-1:0]                   J,
  output logic [WIDTH-1:0]                   K,
  output logic                               BUSY,
  output logic                               ACK,
  output logic                               FAIL,
  output logic [$clog2(MAX_RETRY+2)-1:0]     TRIES
);

  localparam int unsigned TW = $clog2(MAX_RETRY + 2);
  localparam logic [TW-1:0] MaxTries = TW'(MAX_RETRY + 1);

  typedef enum logic [1:0] {StIdle, StDrive, StCheck, StDone} state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d, mask_q, mask_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic [TW-1:0]    tries_q, tries_d;
  logic             fail_q, fail_d;

  logic [WIDTH-1:0] ex_tgt, ex_mask, diff, j_new, k_new;
  logic             match;

  // In IDLE the excitation comes straight from the request; on retry from the captured copy.
  always_comb begin
    ex_tgt  = (state_q == StIdle) ? TGT  : tgt_q;
    ex_mask = (state_q == StIdle) ? MASK : mask_q;
    diff    = ex_mask & (QF ^ ex_tgt);
    j_new   = USE_TOGGLE ? diff : (diff & ex_tgt);
    k_new   = USE_TOGGLE ? diff : (diff & ~ex_tgt);
    match   = ((QF ^ tgt_q) & mask_q) == '0;
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    mask_d  = mask_q;
    j_d     = '0;
    k_d     = '0;
    tries_d = tries_q;
    fail_d  = fail_q;
    unique case (state_q)
      StIdle: begin
        if (REQ) begin
          tgt_d   = TGT;
          mask_d  = MASK;
          tries_d = TW'(1);
          fail_d  = 1'b0;
          j_d     = j_new;
          k_d     = k_new;
          state_d = StDrive;
        end
      end
      StDrive: state_d = StCheck;
      StCheck: begin
        if (match) begin
          fail_d  = 1'b0;
          state_d = StDone;
        end else if (tries_q < MaxTries) begin
          tries_d = tries_q + TW'(1);
          j_d     = j_new;
          k_d     = k_new;
          state_d = StDrive;
        end else begin
          fail_d  = 1'b1;
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      state_q <= StIdle;
      tgt_q   <= '0;
      mask_q  <= '0;
      j_q     <= '0;
      k_q     <= '0;
      tries_q <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      mask_q  <= mask_d;
      j_q     <= j_d;
      k_q     <= k_d;
      tries_q <= tries_d;
      fail_q  <= fail_d;
    end
  end

  assign J     = j_q;
  assign K     = k_q;
  assign BUSY  = (state_q == StDrive) || (state_q == StCheck);
  assign ACK   = (state_q == StDone);
  assign FAIL  = fail_q;
  assign TRIES = tries_q;

endmodule
